shared_reg_arbiter: RTL
=======================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, shall set the width of the shared register and of each data input.
REQ-002 Port clock  input  1  shall be the single clock; all state shall update on its falling edge.
REQ-003 Port clear  input  1  shall be a synchronous, active-high reset sampled on the falling edge of clock.
REQ-004 Port req0  input  1  shall be requester 0's write request, level-sensitive.
REQ-005 Port req1  input  1  shall be requester 1's write request, level-sensitive.
REQ-006 Port d0  input  WIDTH  shall be requester 0's write data.
REQ-007 Port d1  input  WIDTH  shall be requester 1's write data.
REQ-008 Port gnt0 / gnt1  output  1 each  shall be the grant to requester 0 / 1.
REQ-009 Port ack0 / ack1  output  1 each  shall be a one-cycle write-complete pulse to requester 0 / 1.
REQ-010 Port q  output  WIDTH  shall be the shared register contents.
REQ-011 Port qbar  output  WIDTH  shall be the bitwise complement of q, present only per REQ-029.
REQ-012 Port busy  output  1  shall be high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM shall have three states: IDLE, GRANT and ACK, all registered on the falling edge.
REQ-014 IDLE, no request: the FSM shall stay in IDLE with gnt0, gnt1, ack0 and ack1 all low.
REQ-015 IDLE, any request: the FSM shall move to GRANT, latch the selected requester, and raise that requester's gnt on the next falling edge.
REQ-016 GRANT: the next falling edge shall load q with the granted requester's data sampled at that edge, move to ACK, and raise the matching ack.
REQ-017 ACK: the next falling edge shall clear gnt and ack and return the FSM to IDLE.
REQ-018 Write latency shall be 2 falling edges from request sampled to q updated; each transaction shall occupy exactly 3 edges including the IDLE edge.
REQ-019 Arbitration shall be round-robin: on simultaneous req0 and req1, the grant shall go to the requester not served last.
REQ-020 The last-served pointer shall reset to 1, so requester 0 wins the first tie.
REQ-021 At most one gnt and at most one ack shall be high at any time.
REQ-022 Requests arriving while busy shall be ignored until IDLE, then arbitrated normally.
REQ-023 If the granted req drops during GRANT, the write shall still complete with the data present at the GRANT edge.
REQ-024 A req held high through ACK shall be treated as a new request in IDLE, and round-robin shall apply.
REQ-025 q shall hold its value in every state except the GRANT-to-ACK edge.

Reset
REQ-026 When clear is high at a falling edge, the block shall set state to IDLE, q to 0, gnt0/gnt1/ack0/ack1/busy to 0, and the pointer to 1; clear shall override every other input.
REQ-027 A clear asserted mid-transaction shall drop the in-flight write, and no ack shall be issued for it.
REQ-028 Before the first clear, output values shall be unspecified.

Configuration
REQ-029 With macro SHARED_REG_QBAR_EN defined, port qbar shall exist: it shall reset to all ones and be registered alongside q as ~q. Without the macro, port qbar and its register shall be absent and all other behaviour shall be identical.

Verification
REQ-030 clear high for 2 edges -> q=0x00, qbar=0xFF (macro on), gnt/ack/busy=0.
REQ-031 req0=1, d0=0xA5, req1=0 -> gnt0 high after edge 1; q=0xA5 and ack0 pulse after edge 2; idle after edge 3.
REQ-032 req0=req1=1 from reset, d0=0x11, d1=0x22, both held -> first write q=0x11 (ack0), next q=0x22 (ack1), then 0x11 again, alternating.
REQ-033 req1=1 with d1=0x3C; change d1 to 0x7E and drop req1 during GRANT -> q=0x7E, ack1 pulses once.
REQ-034 req0 write of 0x5A in progress; clear high at the GRANT edge -> q=0x00, no ack0, FSM IDLE.
REQ-035 Assertion over all runs -> never gnt0&gnt1 or ack0&ack1; busy equals (state != IDLE).

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Two-requester, round-robin arbitrated write port onto one shared register; all state on the falling clock edge.
// Optional SHARED_REG_QBAR_EN adds a registered complement output qbar.
module shared_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] q,
`ifdef SHARED_REG_QBAR_EN
    output logic [WIDTH-1:0] qbar,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state, state_nx;

    // Requester owning the current transaction; after it completes it doubles
    // as the last-served pointer for the next tie-break.
    logic owner, owner_nx;
    logic load_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        load_q   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx = GRANT;
                    if (req0 && req1) owner_nx = ~owner;
                    else              owner_nx = req1;
                end
            end
            GRANT: begin
                state_nx = ACK;
                load_q   = 1'b1;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so they change only on the falling edge.
    always_comb begin
        busy = (state != IDLE);
        gnt0 = busy & ~owner;
        gnt1 = busy &  owner;
        ack0 = (state == ACK) & ~owner;
        ack1 = (state == ACK) &  owner;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clock) begin
        if (clear) begin
            state <= IDLE;
            owner <= 1'b1;
            q     <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            if (load_q) q <= owner ? d1 : d0;
        end
    end

`ifdef SHARED_REG_QBAR_EN
    always_ff @(negedge clock) begin
        if (clear)       qbar <= '1;
        else if (load_q) qbar <= owner ? ~d1 : ~d0;
    end
`endif

endmodule
